// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory responder with configurable wait states.
//
// Accepts one load/store request at a time, waits WAIT_STATES cycles, performs
// a byte-lane-masked write or a full-word read, and pulses `ready` for one cycle.
// The word array is internal and is not cleared by reset.
//
// Optional feature: define DMEM_RANGE_CHECK_EN to flag addresses whose upper
// bits (a[31:ADDR_WIDTH+2]) are nonzero. Such accesses write nothing, return
// rd=0 and raise err during the response. Without the macro, err is tied low
// and addresses alias modulo 2^(ADDR_WIDTH+2).
//
// Handshake: `req` is sampled only while idle, and the request fields are
// captured on that edge. `ready` is a single-cycle completion pulse. `rd` and
// `err` are valid while `ready` is high and hold until the next access edge.
// The initiator must drop `req` in its `ready` cycle. A `req` still high in the
// following idle cycle starts a new access.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  byteEnable,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [2:0] WS    = 3'(WAIT_STATES);

    state_t state;
    state_t state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;

    logic [31:0] mem [DEPTH];

    // Request fields captured when a request is accepted in IDLE.
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wd_q;
    logic [3:0]            be_q;
    logic                  oor_q;

    // Live view of the request, used directly when there are no wait states.
    logic [ADDR_WIDTH-1:0] idx_live;
    logic                  oor_live;

    // Fields of the access performed on the edge entering RESP.
    logic                  access;
    logic                  use_live;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_wd;
    logic [3:0]            acc_be;
    logic                  acc_oor;

    assign idx_live = a[ADDR_WIDTH+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^a[1:0];
    assign oor_live         = |a[31:ADDR_WIDTH+2];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a[1:0], a[31:ADDR_WIDTH+2]};
    assign oor_live         = 1'b0;
`endif

    // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts one cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        use_live   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    if (WS == 3'd0) begin
                        state_next = S_RESP;
                        access     = 1'b1;
                        use_live   = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WS;
                    end
                end
            end
            S_WAIT: begin
                // A count of 1 means this is the last wait cycle.
                if (cnt <= 3'd1) begin
                    state_next = S_RESP;
                    cnt_next   = 3'd0;
                    access     = 1'b1;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // Select latched or live request fields for the access edge.
    always_comb begin
        acc_we  = we_q;
        acc_idx = idx_q;
        acc_wd  = wd_q;
        acc_be  = be_q;
        acc_oor = oor_q;
        if (use_live) begin
            acc_we  = we;
            acc_idx = idx_live;
            acc_wd  = wd;
            acc_be  = byteEnable;
            acc_oor = oor_live;
        end
    end

    // State, counter, request capture and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            rd    <= 32'd0;
            err   <= 1'b0;
            we_q  <= 1'b0;
            idx_q <= '0;
            wd_q  <= 32'd0;
            be_q  <= 4'd0;
            oor_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_IDLE && req) begin
                we_q  <= we;
                idx_q <= idx_live;
                wd_q  <= wd;
                be_q  <= byteEnable;
                oor_q <= oor_live;
            end
            if (access) begin
                rd  <= (acc_we || acc_oor) ? 32'd0 : mem[acc_idx];
                err <= acc_oor;
            end
        end
    end

    // Lane-masked write; held off while reset is asserted so an aborted
    // request never reaches the array.
    always_ff @(posedge clk) begin
        if (reset && access && acc_we && !acc_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
                end
            end
        end
    end

    assign ready     = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (WAIT_STATES 1, 0, 3) sharing request
// fields, each with its own req strobe, checked every cycle against a
// transaction-level model plus hand-computed literal values.
module tb_dmem_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        req_v [3];
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  byte_en;
    logic [31:0] rd_v  [3];
    logic        ready_v [3];
    logic        busy_v  [3];
    logic        err_v   [3];
    logic [1:0]  dbg_v   [3];

    dmem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .a(a), .wd(wd),
        .byteEnable(byte_en), .rd(rd_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
        .err(err_v[0]), .dbg_state(dbg_v[0]));

    dmem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .a(a), .wd(wd),
        .byteEnable(byte_en), .rd(rd_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
        .err(err_v[1]), .dbg_state(dbg_v[1]));

    dmem_responder #(.ADDR_WIDTH(6), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .a(a), .wd(wd),
        .byteEnable(byte_en), .rd(rd_v[2]), .ready(ready_v[2]), .busy(busy_v[2]),
        .err(err_v[2]), .dbg_state(dbg_v[2]));

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_mis = 0;
    bit chk_on = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [31:0] m_mem [3][64];
    bit          p_pend [3];
    logic        p_we   [3];
    logic [31:0] p_a    [3];
    logic [31:0] p_wd   [3];
    logic [3:0]  p_be   [3];
    int          rdy_at    [3];
    int          busy_from [3];
    logic [31:0] e_rd  [3];
    logic        e_err [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            p_pend[k]    = 1'b0;
            rdy_at[k]    = -1;
            busy_from[k] = 0;
            e_rd[k]      = 32'd0;
            e_err[k]     = 1'b0;
        end
    endtask

    // Record a request accepted at the end of the current cycle.
    task automatic issue(input int k);
        p_pend[k]    = 1'b1;
        p_we[k]      = we;
        p_a[k]       = a;
        p_wd[k]      = wd;
        p_be[k]      = byte_en;
        busy_from[k] = cyc + 1;
        rdy_at[k]    = cyc + 1 + ws_of(k);
    endtask

    // Effect of a completed request on the model memory and response.
    task automatic model_apply(input int k);
        int          idx;
        logic        oor;
        logic [31:0] mask;
        idx = int'((p_a[k] >> 2) & 32'h3F);
`ifdef DMEM_RANGE_CHECK_EN
        oor = ((p_a[k] >> 8) != 32'd0);
`else
        oor = 1'b0;
`endif
        mask = {{8{p_be[k][3]}}, {8{p_be[k][2]}}, {8{p_be[k][1]}}, {8{p_be[k][0]}}};
        if (p_we[k]) begin
            if (!oor) m_mem[k][idx] = (m_mem[k][idx] & ~mask) | (p_wd[k] & mask);
            e_rd[k] = 32'd0;
        end else begin
            e_rd[k] = oor ? 32'd0 : m_mem[k][idx];
        end
        e_err[k]  = oor;
        p_pend[k] = 1'b0;
    endtask

    // Every-cycle comparison of all three responders against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                if (p_pend[k] && cyc == rdy_at[k]) model_apply(k);
                chk($sformatf("ready[%0d]", k), 32'(ready_v[k]), 32'(cyc == rdy_at[k]));
                chk($sformatf("busy[%0d]", k), 32'(busy_v[k]),
                    32'(cyc >= busy_from[k] && cyc <= rdy_at[k]));
                chk($sformatf("rd[%0d]", k), rd_v[k], e_rd[k]);
                chk($sformatf("err[%0d]", k), 32'(err_v[k]), 32'(e_err[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One complete access; returns in the idle cycle after the response.
    task automatic access(input int k, input logic w, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        we = w; a = addr; wd = data; byte_en = be;
        req_v[k] = 1'b1;
        issue(k);
        step();
        req_v[k] = 1'b0;
        // Changes after the request is latched must have no effect.
        we = 1'($urandom); a = $urandom; wd = $urandom; byte_en = 4'($urandom);
        repeat (ws_of(k) + 1) step();
    endtask

    task automatic read_lit(input int k, input logic [31:0] addr,
                            input logic [31:0] lit, input string name);
        access(k, 1'b0, addr, 32'd0, 4'hF);
        exp_q.push_back(lit);
        chk(name, rd_v[k], exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 3; k++) req_v[k] = 1'b0;
        we = 1'b0; a = 32'd0; wd = 32'd0; byte_en = 4'd0;
        model_reset();
        reset = 1'b0;
        chk_on = 1'b1;
        #1;
        chk("reset_rd", rd_v[0], 32'd0);
        chk("reset_ready", 32'(ready_v[0]), 32'd0);
        chk("reset_busy", 32'(busy_v[0]), 32'd0);
        chk("reset_err", 32'(err_v[0]), 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Write then read, WAIT_STATES=1.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        read_lit(0, 32'h10, 32'hDEADBEEF, "ws1_write_read");
        // Lane masking.
        access(0, 1'b1, 32'h10, 32'h11223344, 4'h5);
        read_lit(0, 32'h10, 32'hDE22BE44, "ws1_lane_mask");
        // Empty lane mask completes without changing the word.
        access(0, 1'b1, 32'h10, 32'h55555555, 4'h0);
        chk("ws1_write_rd_zero", rd_v[0], 32'd0);
        read_lit(0, 32'h10, 32'hDE22BE44, "ws1_be_zero");
        // Low address bits are ignored.
        read_lit(0, 32'h13, 32'hDE22BE44, "ws1_low_bits");

        // Zero wait states.
        access(1, 1'b1, 32'h24, 32'h12345678, 4'hF);
        read_lit(1, 32'h24, 32'h12345678, "ws0_read");
        // req held through RESP produces a second access two cycles later.
        we = 1'b0; a = 32'h24; wd = 32'd0; byte_en = 4'hF;
        req_v[1] = 1'b1;
        issue(1);
        step();
        chk("ws0_first_ready", 32'(ready_v[1]), 32'd1);
        step();
        chk("ws0_gap_ready", 32'(ready_v[1]), 32'd0);
        issue(1);
        step();
        chk("ws0_second_ready", 32'(ready_v[1]), 32'd1);
        chk("ws0_second_rd", rd_v[1], 32'h12345678);
        req_v[1] = 1'b0;
        step();

        // Reset during WAIT aborts the write, WAIT_STATES=3.
        access(2, 1'b1, 32'h20, 32'h0BADC0DE, 4'hF);
        read_lit(2, 32'h20, 32'h0BADC0DE, "ws3_read");
        we = 1'b1; a = 32'h20; wd = 32'hCAFEF00D; byte_en = 4'hF;
        req_v[2] = 1'b1;
        issue(2);
        step();
        req_v[2] = 1'b0;
        step();
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_busy", 32'(busy_v[2]), 32'd0);
        chk("abort_ready", 32'(ready_v[2]), 32'd0);
        chk("abort_rd", rd_v[2], 32'd0);
        step();
        step();
        // Request present on the reset-release edge is accepted.
        reset = 1'b1;
        we = 1'b0; a = 32'h20; wd = 32'd0; byte_en = 4'hF;
        req_v[2] = 1'b1;
        issue(2);
        step();
        req_v[2] = 1'b0;
        repeat (ws_of(2) + 1) step();
        chk("abort_prior_contents", rd_v[2], 32'h0BADC0DE);

        // Upper address bits: aliasing or range error.
        access(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
        access(0, 1'b1, 32'h100, 32'h600DF00D, 4'hF);
`ifdef DMEM_RANGE_CHECK_EN
        chk("range_err", 32'(err_v[0]), 32'd1);
        read_lit(0, 32'h0, 32'hA5A5A5A5, "range_word0");
        chk("range_err_clear", 32'(err_v[0]), 32'd0);
`else
        chk("range_err", 32'(err_v[0]), 32'd0);
        read_lit(0, 32'h0, 32'h600DF00D, "range_word0");
`endif

        step();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
